// File: rtl/fetch_pkg.sv
// Shared state encoding and datapath constants for the instruction fetch sequencer.
package fetch_pkg;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 16;

  localparam logic [PC_W-1:0] PC_STEP = 16'd2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    FAULT = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory read bus plus the instruction valid/ready handshake towards decode.
interface fetch_ctrl_if;
  import fetch_pkg::*;

  logic               im_read;
  logic [PC_W-1:0]    im_pc;
  logic [INSTR_W-1:0] im_instr;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    instr_pc;
  logic               instr_valid;
  logic               instr_ready;

  modport master (
    output im_read, im_pc, instr, instr_pc, instr_valid,
    input  im_instr, instr_ready
  );

  modport slave (
    input  im_read, im_pc, instr, instr_pc, instr_valid,
    output im_instr, instr_ready
  );

endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, strobes the instruction memory and hands words to decode.
// Build option FETCH_BOUND_CHK_EN adds the fetch_fault output and the out-of-range FAULT state.
//
// state | meaning
// IDLE  | parked, no fetch issued
// REQ   | read strobe high for one cycle
// WAIT  | counting memory read latency
// HOLD  | instruction presented, waiting for decode to accept
// FAULT | fetch address outside memory, left only by reset or redirect
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int              MEM_BYTES = 32,
  parameter int              READ_LAT  = 1,
  parameter logic [PC_W-1:0] RESET_PC  = 16'h0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  fetch_ctrl_if.master    bus,
`ifdef FETCH_BOUND_CHK_EN
  output logic            fetch_fault,
`endif
  output logic            busy
);

  if (MEM_BYTES < 4 || (MEM_BYTES & (MEM_BYTES - 1)) != 0 ||
      READ_LAT < 1 || READ_LAT > 7 || RESET_PC[0]) begin : g_bad_cfg
    $error("fetch_ctrl: illegal parameter combination");
  end

  localparam logic [2:0] LP_CNT_LOAD = 3'(READ_LAT - 1);

  fetch_state_t       r_state;
  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    r_im_pc;
  logic               r_im_read;
  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_instr_pc;
  logic               r_instr_valid;
  logic [2:0]         r_cnt;

  logic [PC_W-1:0]    w_tgt;
  logic               w_xfer;
  logic               w_oob_pc;
  logic               w_oob_tgt;

  assign w_tgt  = {redirect_pc[PC_W-1:1], 1'b0};
  assign w_xfer = r_instr_valid & bus.instr_ready;

`ifdef FETCH_BOUND_CHK_EN
  localparam logic [PC_W:0] LP_LIMIT = (PC_W + 1)'(MEM_BYTES);
  logic r_fault;
  assign w_oob_pc    = {1'b0, r_pc} >= LP_LIMIT;
  assign w_oob_tgt   = {1'b0, w_tgt} >= LP_LIMIT;
  assign fetch_fault = r_fault;
`else
  assign w_oob_pc  = 1'b0;
  assign w_oob_tgt = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_pc          <= RESET_PC;
      r_im_pc       <= RESET_PC;
      r_im_read     <= 1'b0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_cnt         <= '0;
`ifdef FETCH_BOUND_CHK_EN
      r_fault       <= 1'b0;
`endif
    end else if (redirect) begin
      r_pc          <= w_tgt;
      r_instr_valid <= 1'b0;
      r_cnt         <= '0;
`ifdef FETCH_BOUND_CHK_EN
      r_fault       <= run & w_oob_tgt;
`endif
      if (!run) begin
        r_state   <= IDLE;
        r_im_read <= 1'b0;
      end else if (w_oob_tgt) begin
        r_state   <= FAULT;
        r_im_read <= 1'b0;
        r_im_pc   <= w_tgt;
      end else begin
        // A strobe already high must drop for a cycle so memory sees a fresh edge.
        r_state   <= REQ;
        r_im_read <= ~r_im_read;
        r_im_pc   <= w_tgt;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (run) begin
            r_im_pc <= r_pc;
            if (w_oob_pc) begin
              r_state <= FAULT;
`ifdef FETCH_BOUND_CHK_EN
              r_fault <= 1'b1;
`endif
            end else begin
              r_state   <= REQ;
              r_im_read <= 1'b1;
            end
          end
        end
        REQ: begin
          if (r_im_read) begin
            r_im_read <= 1'b0;
            r_cnt     <= LP_CNT_LOAD;
            r_state   <= WAIT;
          end else begin
            r_im_read <= 1'b1;
          end
        end
        WAIT: begin
          if (r_cnt == 3'd0) begin
            r_instr       <= bus.im_instr;
            r_instr_pc    <= r_pc;
            r_pc          <= r_pc + PC_STEP;
            r_instr_valid <= 1'b1;
            r_state       <= HOLD;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        HOLD: begin
          if (w_xfer) begin
            r_instr_valid <= 1'b0;
            if (run) begin
              r_im_pc <= r_pc;
              if (w_oob_pc) begin
                r_state <= FAULT;
`ifdef FETCH_BOUND_CHK_EN
                r_fault <= 1'b1;
`endif
              end else begin
                r_state   <= REQ;
                r_im_read <= 1'b1;
              end
            end else begin
              r_state <= IDLE;
            end
          end
        end
        FAULT:   r_state <= FAULT;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.im_read     = r_im_read;
  assign bus.im_pc       = r_im_pc;
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.instr_valid = r_instr_valid;
  assign busy            = (r_state != IDLE);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: behavioural instruction memory plus strobe and transfer scoreboards.
module tb_fetch_ctrl;

  localparam int MEM_BYTES = 32;
  localparam int READ_LAT  = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        busy;
`ifdef FETCH_BOUND_CHK_EN
  logic        fetch_fault;
`endif

  fetch_ctrl_if bus();

  fetch_ctrl #(
    .MEM_BYTES (MEM_BYTES),
    .READ_LAT  (READ_LAT),
    .RESET_PC  (16'h0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus.master),
`ifdef FETCH_BOUND_CHK_EN
    .fetch_fault (fetch_fault),
`endif
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem [0:MEM_BYTES-1];
  logic [15:0] strobe_q [$];
  logic [31:0] xfer_q [$];
  logic        prev_rd = 1'b0;

  function automatic logic [15:0] word(input logic [15:0] a);
    int idx;
    idx = int'(a);
    if (idx < MEM_BYTES - 1) return {mem[idx+1], mem[idx]};
    return 16'hBAD0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (bus.instr_valid !== 1'b1 && n < 20) begin
      cyc(1);
      n++;
    end
    chk(tag, 32'(bus.instr_valid), 32'd1);
  endtask

  // Memory: samples the address on the strobe's rising edge, data stable READ_LAT cycles later.
  initial begin
    logic [15:0] a;
    bus.im_instr = 16'h0000;
    forever begin
      @(posedge bus.im_read);
      #1;
      a = bus.im_pc;
      repeat (READ_LAT) @(posedge clk);
      #1;
      bus.im_instr = word(a);
    end
  end

  always @(negedge clk) begin
    logic [31:0] e;
    if (bus.im_read && !prev_rd) begin
      e = (strobe_q.size() != 0) ? 32'(strobe_q.pop_front()) : 32'hFFFF_FFFF;
      chk("strobe_pc", 32'(bus.im_pc), e);
    end
    prev_rd = bus.im_read;
    if (bus.instr_valid && bus.instr_ready) begin
      e = (xfer_q.size() != 0) ? xfer_q.pop_front() : 32'hFFFF_FFFF;
      chk("xfer", {bus.instr, bus.instr_pc}, e);
    end
  end

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'(i * 37 + 5);
    mem[0] = 8'h34;
    mem[1] = 8'h12;
    rst = 1'b1; run = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    bus.instr_ready = 1'b0;
    cyc(2);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_im_read", 32'(bus.im_read), 0);
    chk("rst_im_pc", 32'(bus.im_pc), 0);
    chk("rst_valid", 32'(bus.instr_valid), 0);
    chk("rst_instr", 32'(bus.instr), 0);
    chk("rst_instr_pc", 32'(bus.instr_pc), 0);

    // First fetch with decode always ready
    strobe_q.push_back(16'h0000); xfer_q.push_back({16'h1234, 16'h0000});
    strobe_q.push_back(16'h0002); xfer_q.push_back({word(16'h0002), 16'h0002});
    rst = 1'b0; run = 1'b1; bus.instr_ready = 1'b1;
    cyc(1);
    chk("a_im_read", 32'(bus.im_read), 1);
    chk("a_busy", 32'(busy), 1);
    cyc(1);
    chk("a_wait_read", 32'(bus.im_read), 0);
    chk("a_wait_valid", 32'(bus.instr_valid), 0);
    cyc(1);
    chk("a_valid", 32'(bus.instr_valid), 1);
    chk("a_instr", 32'(bus.instr), 32'h1234);
    chk("a_instr_pc", 32'(bus.instr_pc), 0);
    cyc(1);
    chk("a_next_read", 32'(bus.im_read), 1);
    chk("a_next_pc", 32'(bus.im_pc), 2);
    bus.instr_ready = 1'b0;

    // Back-pressure in HOLD
    wait_valid("b_valid_to");
    for (int i = 0; i < 5; i++) begin
      chk("b_hold_instr", 32'(bus.instr), 32'(word(16'h0002)));
      chk("b_hold_pc", 32'(bus.instr_pc), 2);
      chk("b_hold_read", 32'(bus.im_read), 0);
      chk("b_hold_valid", 32'(bus.instr_valid), 1);
      cyc(1);
    end
    strobe_q.push_back(16'h0004); xfer_q.push_back({word(16'h0004), 16'h0004});
    bus.instr_ready = 1'b1;
    cyc(1);
    bus.instr_ready = 1'b0;
    chk("b_req_read", 32'(bus.im_read), 1);
    chk("b_req_pc", 32'(bus.im_pc), 4);
    wait_valid("b2_valid_to");
    chk("b2_instr_pc", 32'(bus.instr_pc), 4);

    // Redirect coinciding with the transfer of pc 4
    strobe_q.push_back(16'h0010); xfer_q.push_back({word(16'h0010), 16'h0010});
    bus.instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h0010;
    cyc(1);
    redirect = 1'b0; bus.instr_ready = 1'b0;
    chk("d_im_pc", 32'(bus.im_pc), 32'h10);
    chk("d_im_read", 32'(bus.im_read), 1);
    chk("d_valid", 32'(bus.instr_valid), 0);
    wait_valid("d_valid_to");
    chk("d_instr_pc", 32'(bus.instr_pc), 32'h10);

    // Redirect to an odd target while WAIT is in progress
    strobe_q.push_back(16'h0012);
    bus.instr_ready = 1'b1;
    cyc(1);
    bus.instr_ready = 1'b0;
    chk("c_req_pc", 32'(bus.im_pc), 32'h12);
    cyc(1);
    chk("c_wait_read", 32'(bus.im_read), 0);
    strobe_q.push_back(16'h0008); xfer_q.push_back({word(16'h0008), 16'h0008});
    redirect = 1'b1; redirect_pc = 16'h0009;
    cyc(1);
    redirect = 1'b0;
    chk("c_redir_pc", 32'(bus.im_pc), 8);
    chk("c_redir_read", 32'(bus.im_read), 1);
    chk("c_redir_valid", 32'(bus.instr_valid), 0);
    cyc(1);
    chk("c_discard_valid", 32'(bus.instr_valid), 0);
    wait_valid("c_valid_to");
    chk("c_instr", 32'(bus.instr), 32'(word(16'h0008)));

    // run falls during WAIT: fetch completes, then park
    strobe_q.push_back(16'h000A); xfer_q.push_back({word(16'h000A), 16'h000A});
    bus.instr_ready = 1'b1;
    cyc(1);
    bus.instr_ready = 1'b0;
    cyc(1);
    run = 1'b0;
    wait_valid("e_valid_to");
    chk("e_instr_pc", 32'(bus.instr_pc), 32'h0A);
    bus.instr_ready = 1'b1;
    cyc(1);
    chk("e_idle_busy", 32'(busy), 0);
    chk("e_idle_valid", 32'(bus.instr_valid), 0);
    cyc(3);
    chk("e_park_busy", 32'(busy), 0);
    chk("e_park_read", 32'(bus.im_read), 0);

    // Reset in the middle of WAIT
    strobe_q.push_back(16'h000C);
    run = 1'b1; bus.instr_ready = 1'b0;
    cyc(1);
    chk("f_req_pc", 32'(bus.im_pc), 32'h0C);
    cyc(1);
    chk("f_wait_busy", 32'(busy), 1);
    rst = 1'b1;
    cyc(1);
    chk("f_rst_busy", 32'(busy), 0);
    chk("f_rst_im_read", 32'(bus.im_read), 0);
    chk("f_rst_im_pc", 32'(bus.im_pc), 0);
    chk("f_rst_valid", 32'(bus.instr_valid), 0);
    chk("f_rst_instr", 32'(bus.instr), 0);
    chk("f_rst_instr_pc", 32'(bus.instr_pc), 0);

    // Restart from RESET_PC; run dropped while in REQ
    strobe_q.push_back(16'h0000); xfer_q.push_back({16'h1234, 16'h0000});
    rst = 1'b0; run = 1'b1; bus.instr_ready = 1'b1;
    cyc(1);
    chk("g_req_read", 32'(bus.im_read), 1);
    run = 1'b0;
    wait_valid("g_valid_to");
    chk("g_instr", 32'(bus.instr), 32'h1234);
    cyc(1);
    chk("g_idle_busy", 32'(busy), 0);

`ifdef FETCH_BOUND_CHK_EN
    // Out-of-range redirect, then recovery
    run = 1'b1; redirect = 1'b1; redirect_pc = 16'h0020;
    cyc(1);
    redirect = 1'b0;
    chk("h_fault", 32'(fetch_fault), 1);
    chk("h_fault_read", 32'(bus.im_read), 0);
    chk("h_fault_busy", 32'(busy), 1);
    cyc(3);
    chk("h_fault_stay", 32'(fetch_fault), 1);
    chk("h_fault_noread", 32'(bus.im_read), 0);
    strobe_q.push_back(16'h0004); xfer_q.push_back({word(16'h0004), 16'h0004});
    redirect = 1'b1; redirect_pc = 16'h0004;
    cyc(1);
    redirect = 1'b0; run = 1'b0;
    chk("h_clear", 32'(fetch_fault), 0);
    chk("h_req_read", 32'(bus.im_read), 1);
    chk("h_req_pc", 32'(bus.im_pc), 4);
    wait_valid("h_valid_to");
    cyc(1);
`endif

    cyc(3);
    chk("strobe_q_drained", 32'(strobe_q.size()), 0);
    chk("xfer_q_drained", 32'(xfer_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
